// File: rtl/de1_square_plotter.sv
// -----------------------------------------------------------------------------
// de1_square_plotter
//
// Top-level user logic for the 160x120 board/VGA environment. The switches
// supply an origin (loaded by KEY[3] for X and KEY[2] for Y) and a colour.
// KEY[1] then draws an SQ_SIZE x SQ_SIZE square at that origin, one pixel
// per clock in x-fast raster order. Pixels that fall off the right or bottom
// edge still take their cycle, but with plot held low.
//
// Optional feature: define DEBOUNCE_EN to debounce KEY[3:1]. Each key must
// then hold a new level for DEBOUNCE_CYCLES consecutive clocks before it is
// seen. KEY[0] is never debounced.
//
// Ports:
//   CLOCK_50    in   1   sole clock, rising edge
//   KEY         in   4   push buttons, active-low; KEY[0] = synchronous reset,
//                        KEY[3] = load X, KEY[2] = load Y, KEY[1] = draw
//   SW          in  10   SW[7:0] X value, SW[6:0] Y value, SW[9:7] colour
//   HEX0..HEX5  out  7   seven-segment, active-low, bit0 = a .. bit6 = g
//                        HEX1:HEX0 = X origin, HEX3:HEX2 = Y origin,
//                        HEX4 = latched colour, HEX5 = 0 (idle) / d (drawing)
//   LEDR        out 10   [0] busy, [6:1] zero, [9:7] latched colour
//   x           out  8   pixel x
//   y           out  7   pixel y
//   colour      out  3   pixel colour
//   plot        out  1   pixel written on each clock it is high
//   vga_resetn  out  1   low clears the frame to black
// -----------------------------------------------------------------------------
module de1_square_plotter #(
    parameter int SQ_SIZE         = 4,
    parameter int SCREEN_W        = 160,
    parameter int SCREEN_H        = 120,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       vga_resetn
);

    // Reject parameter values the square counters cannot represent.
    if (SQ_SIZE < 1 || SQ_SIZE > 8 || DEBOUNCE_CYCLES < 1) begin : gBadParam
        $error("de1_square_plotter: SQ_SIZE must be 1..8, DEBOUNCE_CYCLES >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_e;

    localparam logic [2:0] LAST_C  = 3'(SQ_SIZE - 1);
    localparam logic [7:0] X_MAX   = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_MAX   = 7'(SCREEN_H - 1);

    logic       resetn;
    assign resetn = KEY[0];

    // Key conditioning state for KEY[3:1]; bit 0 of these vectors is unused
    // storage-free padding avoided by indexing [3:1].
    logic [3:1] keySync1_q;
    logic [3:1] keySync2_q;
    logic [3:1] keyPrev_q;
    logic [3:1] keyLevel;
    logic [3:1] keyPress;

    // Drawing state
    state_e     state_q, state_d;
    logic [7:0] xOrg_q, xOrg_d;
    logic [6:0] yOrg_q, yOrg_d;
    logic [2:0] colLatch_q, colLatch_d;
    logic [2:0] cx_q, cx_d;
    logic [2:0] cy_q, cy_d;

    // Registered pixel interface
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       pixelValid_q, pixelValid_d;
    logic       vgaResetn_q;

    logic [8:0] sumX;
    logic [7:0] sumY;
    logic [7:0] clampX;
    logic [6:0] clampY;

    // Two-flop synchronizer on the action keys, plus the previous-value flop
    // used for falling-edge (press) detection. KEY[0] stays raw by design.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            keySync1_q <= 3'b111;
            keySync2_q <= 3'b111;
            keyPrev_q  <= 3'b111;
        end else begin
            keySync1_q <= KEY[3:1];
            keySync2_q <= keySync1_q;
            keyPrev_q  <= keyLevel;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    logic [3:1]     keyDeb_q;
    logic [DCW-1:0] debCnt_q [3:1];

    // Per-key debouncer: the filtered level flips only once the synchronized
    // input has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
    // Any agreement in between restarts the count, so short glitches vanish.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            keyDeb_q <= 3'b111;
            for (int i = 1; i <= 3; i++) begin
                debCnt_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i <= 3; i++) begin
                if (keySync2_q[i] != keyDeb_q[i]) begin
                    if (debCnt_q[i] == DEB_LAST) begin
                        keyDeb_q[i] <= keySync2_q[i];
                        debCnt_q[i] <= '0;
                    end else begin
                        debCnt_q[i] <= debCnt_q[i] + 1'b1;
                    end
                end else begin
                    debCnt_q[i] <= '0;
                end
            end
        end
    end

    assign keyLevel = keyDeb_q;
`else
    assign keyLevel = keySync2_q;
`endif

    // A press is a released-to-pressed (1 -> 0) transition of the key level.
    assign keyPress = keyPrev_q & ~keyLevel;

    // Origin clamping keeps the latched origin on screen; the square itself
    // may still run past the edge and is clipped pixel by pixel.
    assign clampX = (SW[7:0] > X_MAX) ? X_MAX : SW[7:0];
    assign clampY = (SW[6:0] > Y_MAX) ? Y_MAX : SW[6:0];

    // Widened sums so the on-screen test sees carries past the screen size.
    assign sumX = {1'b0, xOrg_q} + {6'b0, cx_q};
    assign sumY = {1'b0, yOrg_q} + {5'b0, cy_q};

    // Next-state and pixel logic. IDLE accepts key actions (all simultaneous
    // presses apply together; a draw started alongside a load uses the new
    // origin because DRAW reads the origin registers a cycle later). DRAW
    // emits one pixel per clock and ignores keys entirely.
    always_comb begin
        state_d      = state_q;
        xOrg_d       = xOrg_q;
        yOrg_d       = yOrg_q;
        colLatch_d   = colLatch_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        pixelValid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (keyPress[3]) begin
                    xOrg_d = clampX;
                end
                if (keyPress[2]) begin
                    yOrg_d = clampY;
                end
                if (keyPress[1]) begin
                    colLatch_d = SW[9:7];
                    cx_d       = 3'd0;
                    cy_d       = 3'd0;
                    state_d    = DRAW;
                end
            end

            DRAW: begin
                x_d          = sumX[7:0];
                y_d          = sumY[6:0];
                colour_d     = colLatch_q;
                plot_d       = (sumX < 9'(SCREEN_W)) && (sumY < 8'(SCREEN_H));
                pixelValid_d = 1'b1;
                if (cx_q == LAST_C) begin
                    cx_d = 3'd0;
                    if (cy_q == LAST_C) begin
                        cy_d    = 3'd0;
                        state_d = IDLE;
                    end else begin
                        cy_d = cy_q + 3'd1;
                    end
                end else begin
                    cx_d = cx_q + 3'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any draw in progress and
    // holds the frame clear; vga_resetn rises on the first released edge.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q      <= IDLE;
            xOrg_q       <= 8'd0;
            yOrg_q       <= 7'd0;
            colLatch_q   <= 3'd0;
            cx_q         <= 3'd0;
            cy_q         <= 3'd0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            colour_q     <= 3'd0;
            plot_q       <= 1'b0;
            pixelValid_q <= 1'b0;
            vgaResetn_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            xOrg_q       <= xOrg_d;
            yOrg_q       <= yOrg_d;
            colLatch_q   <= colLatch_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            pixelValid_q <= pixelValid_d;
            vgaResetn_q  <= 1'b1;
        end
    end

    // Standard active-low 0-F glyphs, segment g in bit 6 down to a in bit 0.
    function automatic logic [6:0] hexSeg(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign HEX0 = hexSeg(xOrg_q[3:0]);
    assign HEX1 = hexSeg(xOrg_q[7:4]);
    assign HEX2 = hexSeg(yOrg_q[3:0]);
    assign HEX3 = hexSeg({1'b0, yOrg_q[6:4]});
    assign HEX4 = hexSeg({1'b0, colLatch_q});
    assign HEX5 = (state_q == DRAW) ? hexSeg(4'hD) : hexSeg(4'h0);

    // Busy covers the whole visible drawing window: from entering DRAW until
    // the last pixel (clipped or not) has been presented on the outputs.
    assign LEDR = {colLatch_q, 6'b000000, (state_q == DRAW) | pixelValid_q};

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign vga_resetn = vgaResetn_q;

endmodule

// File: tb/tb_de1_square_plotter.sv
// -----------------------------------------------------------------------------
// tb_de1_square_plotter
//
// Directed bench for de1_square_plotter with hand-computed expectations:
// reset values, origin loading with clamping, a full draw, a clipped draw,
// key presses ignored while drawing, and a reset that aborts a draw. With
// DEBOUNCE_EN defined it also checks glitch rejection and the added latency.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_de1_square_plotter;

`ifdef DEBOUNCE_EN
    localparam int EXTRA = 4;
`else
    localparam int EXTRA = 0;
`endif

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] SEG_D = 7'b0100001;

    logic       CLOCK_50;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       vga_resetn;

    int testCount = 0;
    int failCount = 0;

    de1_square_plotter dut (
        .CLOCK_50  (CLOCK_50),
        .KEY       (KEY),
        .SW        (SW),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5),
        .LEDR      (LEDR),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .vga_resetn(vga_resetn)
    );

    // 50 MHz-style free-running clock
    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Press one action key with the given switches, release it, let things
    // settle, and confirm that no pixel was plotted meanwhile
    task automatic applyStimulus(input int keyIdx, input logic [9:0] sw);
        int plotSeen;
        plotSeen = 0;
        @(negedge CLOCK_50);
        SW = sw;
        KEY[keyIdx] = 1'b0;
        repeat (8) begin
            @(negedge CLOCK_50);
            plotSeen += int'(plot);
        end
        KEY[keyIdx] = 1'b1;
        repeat (12) begin
            @(negedge CLOCK_50);
            plotSeen += int'(plot);
        end
        checkOutput("noPlotDuringLoad", plotSeen, 0);
    endtask

    // Start a draw and check every pixel against the expected raster.
    // doIgnore presses KEY[3] mid-draw; abortAt >= 0 pulls reset at that
    // pixel index and checks that the draw never resumes.
    task automatic runDraw(input logic [9:0] sw, input int oxE, input int oyE,
                           input int colE, input bit doIgnore, input int abortAt);
        int px, py, expPlot, plotSeen;
        @(negedge CLOCK_50);
        SW = sw;
        KEY[1] = 1'b0;
        repeat (3 + EXTRA) @(negedge CLOCK_50);
        checkOutput("plotBeforeFirstPixel", plot, 0);
        checkOutput("busyOnDrawEntry", LEDR[0], 1);
        @(negedge CLOCK_50);
        for (int i = 0; i < 16; i++) begin
            if (i == abortAt) begin
                KEY[0] = 1'b0;
                @(negedge CLOCK_50);
                checkOutput("abortPlot", plot, 0);
                checkOutput("abortX", x, 0);
                checkOutput("abortY", y, 0);
                checkOutput("abortVgaResetn", vga_resetn, 0);
                checkOutput("abortLedr", LEDR, 0);
                KEY[0] = 1'b1;
                plotSeen = 0;
                repeat (30) begin
                    @(negedge CLOCK_50);
                    plotSeen += int'(plot);
                end
                checkOutput("noResumeAfterAbort", plotSeen, 0);
                checkOutput("abortHex5Idle", HEX5, SEG_0);
                return;
            end
            px = oxE + (i % 4);
            py = oyE + (i / 4);
            expPlot = (px < 160 && py < 120) ? 1 : 0;
            checkOutput($sformatf("plot[%0d]", i), plot, expPlot);
            checkOutput($sformatf("x[%0d]", i), x, px);
            checkOutput($sformatf("y[%0d]", i), y, py);
            checkOutput($sformatf("colour[%0d]", i), colour, colE);
            checkOutput($sformatf("busy[%0d]", i), LEDR[0], 1);
            if (i == 0) begin
                checkOutput("hex5Draw", HEX5, SEG_D);
                checkOutput("ledrColour", LEDR[9:7], colE);
            end
            if (i == 2) begin
                KEY[1] = 1'b1;
                if (doIgnore) begin
                    SW = 10'h005;
                    KEY[3] = 1'b0;
                end
            end
            if (i == 9) begin
                KEY[3] = 1'b1;
            end
            @(negedge CLOCK_50);
        end
        checkOutput("plotAfterDraw", plot, 0);
        checkOutput("busyAfterDraw", LEDR[0], 0);
        checkOutput("hex5AfterDraw", HEX5, SEG_0);
        repeat (10) @(negedge CLOCK_50);
    endtask

    initial begin
        KEY = 4'b1110;
        SW  = 10'h000;

        // Reset held for three clocks
        repeat (3) @(negedge CLOCK_50);
        checkOutput("resetVgaResetn", vga_resetn, 0);
        checkOutput("resetPlot", plot, 0);
        checkOutput("resetLedr", LEDR, 0);
        checkOutput("resetHex0", HEX0, SEG_0);
        checkOutput("resetHex1", HEX1, SEG_0);
        checkOutput("resetHex2", HEX2, SEG_0);
        checkOutput("resetHex3", HEX3, SEG_0);
        checkOutput("resetHex4", HEX4, SEG_0);
        checkOutput("resetHex5", HEX5, SEG_0);
        KEY = 4'b1111;
        @(negedge CLOCK_50);
        checkOutput("vgaResetnRelease", vga_resetn, 1);

        // Load origin (10, 20)
        applyStimulus(3, 10'h00A);
        applyStimulus(2, 10'h014);
        checkOutput("loadHex1", HEX1, SEG_0);
        checkOutput("loadHex0", HEX0, SEG_A);
        checkOutput("loadHex3", HEX3, SEG_1);
        checkOutput("loadHex2", HEX2, SEG_4);

        // Full on-screen draw in colour 5
        runDraw(10'h280, 10, 20, 5, 1'b0, -1);
        checkOutput("hex4Colour5", HEX4, SEG_5);

        // Clamped X origin and clipped square at the bottom-right corner
        applyStimulus(3, 10'd200);
        applyStimulus(2, 10'd118);
        checkOutput("clampHex1", HEX1, SEG_9);
        checkOutput("clampHex0", HEX0, SEG_F);
        checkOutput("clampHex3", HEX3, SEG_7);
        checkOutput("clampHex2", HEX2, SEG_6);
        runDraw(10'h000, 159, 118, 0, 1'b0, -1);

        // KEY[3] pressed during a draw must not change the origin
        runDraw(10'h180, 159, 118, 3, 1'b1, -1);
        checkOutput("ignoredHex1", HEX1, SEG_9);
        checkOutput("ignoredHex0", HEX0, SEG_F);

        // Reset at pixel 5 aborts the draw and clears the origin
        runDraw(10'h100, 159, 118, 2, 1'b0, 5);
        checkOutput("abortHex1", HEX1, SEG_0);
        checkOutput("abortHex0", HEX0, SEG_0);

`ifdef DEBOUNCE_EN
        // A two-clock glitch on KEY[1] must not start a draw
        begin
            int plotSeen;
            plotSeen = 0;
            @(negedge CLOCK_50);
            KEY[1] = 1'b0;
            repeat (2) @(negedge CLOCK_50);
            KEY[1] = 1'b1;
            repeat (30) begin
                @(negedge CLOCK_50);
                plotSeen += int'(plot) + int'(LEDR[0]);
            end
            checkOutput("glitchNoDraw", plotSeen, 0);
        end
        // A long press draws after the extra debounce latency
        runDraw(10'h080, 0, 0, 1, 1'b0, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
